// File: rtl/icache_pkg.sv
// Shared geometry, types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned LINE_ADDR_LEN = 3;
    localparam int unsigned INDEX_LEN     = 6;
    localparam int unsigned TAG_LEN       = 32 - INDEX_LEN - LINE_ADDR_LEN - 2;
    localparam int unsigned LINE_WORDS    = 1 << LINE_ADDR_LEN;
    localparam int unsigned LINE_COUNT    = 1 << INDEX_LEN;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic [LINE_WORDS-1:0][31:0] line_t;

    function automatic logic [LINE_ADDR_LEN-1:0] addr_offset(input logic [31:0] addr);
        return addr[LINE_ADDR_LEN+1:2];
    endfunction

    function automatic logic [INDEX_LEN-1:0] addr_index(input logic [31:0] addr);
        return addr[LINE_ADDR_LEN+2 +: INDEX_LEN];
    endfunction

    function automatic logic [TAG_LEN-1:0] addr_tag(input logic [31:0] addr);
        return addr[31 -: TAG_LEN];
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:LINE_ADDR_LEN+2], {(LINE_ADDR_LEN+2){1'b0}}};
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays: one combinational read port, one synchronous line write port,
// and a whole-array valid clear.
module icache_line_store
    import icache_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [INDEX_LEN-1:0] rd_index,
    output logic [TAG_LEN-1:0]   rd_tag,
    output logic                 rd_valid,
    output line_t                rd_line,
    input  logic                 wr_en,
    input  logic [INDEX_LEN-1:0] wr_index,
    input  logic [TAG_LEN-1:0]   wr_tag,
    input  line_t                wr_line,
    input  logic                 wr_set_valid,
    input  logic                 clear_valid
);

    logic [LINE_COUNT-1:0] valid_q;
    logic [TAG_LEN-1:0]    tag_q  [LINE_COUNT];
    line_t                 data_q [LINE_COUNT];

    // A line write applies after the clear, so the writer decides whether it survives a flush.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q <= '0;
        end else begin
            if (clear_valid) begin
                valid_q <= '0;
            end
            if (wr_en) begin
                valid_q[wr_index] <= wr_set_valid;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-line refill over the
// AXI line bridge on a miss, requested word delivered from a refill buffer.
module icache_dm
    import icache_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        flush,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_rd_req,
    input  line_t       mem_rd_line,
    output logic        mem_wr_req,
    output line_t       mem_wr_line
);

    state_t      state_q, state_d;
    logic [31:0] miss_addr_q, miss_addr_d;
    logic        flush_pend_q, flush_pend_d;
    line_t       refill_buf_q, refill_buf_d;

    logic [TAG_LEN-1:0] rd_tag;
    logic               rd_valid;
    line_t              rd_line;
    logic               hit;
    logic               wr_en;
    logic               wr_set_valid;

    icache_line_store u_store (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .rd_index     (addr_index(cpu_addr)),
        .rd_tag       (rd_tag),
        .rd_valid     (rd_valid),
        .rd_line      (rd_line),
        .wr_en        (wr_en),
        .wr_index     (addr_index(miss_addr_q)),
        .wr_tag       (addr_tag(miss_addr_q)),
        .wr_line      (mem_rd_line),
        .wr_set_valid (wr_set_valid),
        .clear_valid  (flush)
    );

    assign hit = cpu_req && rd_valid && (rd_tag == addr_tag(cpu_addr));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            flush_pend_q <= 1'b0;
            refill_buf_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            flush_pend_q <= flush_pend_d;
            refill_buf_q <= refill_buf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        refill_buf_d = refill_buf_q;
        cpu_rdata    = '0;
        cpu_stall    = 1'b0;
        mem_rd_req   = 1'b0;
        wr_en        = 1'b0;
        wr_set_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                flush_pend_d = 1'b0;
                if (hit) begin
                    cpu_rdata = rd_line[addr_offset(cpu_addr)];
                end else if (cpu_req) begin
                    cpu_stall   = 1'b1;
                    miss_addr_d = cpu_addr;
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                mem_rd_req = 1'b1;
                cpu_stall  = 1'b1;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_gnt) begin
                    // A flush seen at any point of the refill leaves the new line invalid.
                    wr_en        = 1'b1;
                    wr_set_valid = !(flush || flush_pend_q);
                    refill_buf_d = mem_rd_line;
                    state_d      = RESP;
                end
            end
            RESP: begin
                cpu_rdata = refill_buf_q[addr_offset(miss_addr_q)];
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr    = line_base(miss_addr_q);
    assign mem_wr_req  = 1'b0;
    assign mem_wr_line = '0;

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache sitting between the CPU fetch stage and the AXI line bridge.
- Serves hits combinationally from local arrays.
- On a miss, issues a whole-line read request to the AXI line bridge, installs the returned 8-word line, then delivers the requested word.
- Never issues writes: mem_wr_req is tied 0 and mem_wr_line is all zeros.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (8 words = 32 B); must match the bridge.
- INDEX_LEN, 6, log2 of line count (64 lines); tag width = 32 - INDEX_LEN - LINE_ADDR_LEN - 2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cpu_req  in  1  fetch request valid
- cpu_addr  in  32  fetch byte address; bits [1:0] ignored
- cpu_rdata  out  32  fetched instruction word
- cpu_stall  out  1  fetch not complete; CPU holds cpu_req/cpu_addr
- flush  in  1  one-cycle pulse; invalidate all lines
- mem_gnt  in  1  bridge line transfer done; mem_rd_line valid this cycle
- mem_addr  out  32  line-aligned address to bridge
- mem_rd_req  out  1  line read request
- mem_rd_line  in  32x8  returned line, word i at offset i
- mem_wr_req  out  1  constant 0
- mem_wr_line  out  32x8  constant 0

Behaviour:
- Address split: offset = addr[LINE_ADDR_LEN+1:2], index = next INDEX_LEN bits, tag = remaining upper bits.
- Reset (async, aresetn=0):
  - all valid bits 0; state IDLE; miss address register 0.
  - mem_rd_req=0, mem_addr=0, cpu_stall=0, cpu_rdata=0.
- States IDLE, REFILL, RESP.
- IDLE:
  - hit = cpu_req && valid[index] && tag_arr[index]==tag.
  - Hit: cpu_rdata = data[index][offset] same cycle, cpu_stall=0, zero latency.
  - Miss (cpu_req && !hit): cpu_stall=1; latch cpu_addr into miss_addr; -> REFILL.
  - cpu_req=0: cpu_stall=0, cpu_rdata=0.
- REFILL:
  - mem_rd_req=1; mem_addr = {miss_addr[31:LINE_ADDR_LEN+2], zeros}; both held constant until mem_gnt.
  - cpu_stall=1.
  - On mem_gnt: write mem_rd_line into data[miss index], write tag, set valid; capture line into refill buffer; -> RESP.
- RESP:
  - cpu_rdata = refill_buf[miss offset]; cpu_stall=0; mem_rd_req=0; -> IDLE.
- mem_rd_req is a pure decode of state==REFILL, so it drops the cycle after mem_gnt; the bridge must never see a request in its gnt cycle that it would re-trigger on.
- Miss latency: miss cycle + bridge time + 1 RESP cycle.
- flush:
  - Clears all valid bits next edge.
  - In IDLE it takes effect the same cycle as a lookup: the lookup still uses pre-flush valid bits.
  - During REFILL it is remembered; the line is still delivered in RESP but its valid bit is left 0.
  - flush coincident with mem_gnt: line not validated.
- Requests are not queued: the CPU must hold cpu_req/cpu_addr stable while cpu_stall=1. Changes during REFILL are ignored; miss_addr is used.
- Refill of an index overwrites the previous tag; no victim handling is needed because the cache is read-only.
- Reset mid-REFILL: immediate IDLE, mem_rd_req=0, no line installed; the bridge resets on the same aresetn.

Decomposition:
- Package icache_pkg holds:
  - LINE_ADDR_LEN, INDEX_LEN, TAG_LEN
  - state enum {IDLE, REFILL, RESP}
  - line_t typedef (8 x 32-bit array)
  - address-field extraction functions
- One sub-module, icache_line_store:
  - tag, valid and data arrays
  - combinational read port by index
  - single synchronous write port (index, tag, line, set_valid)
  - global async/sync clear of valid bits

Test Plan:
- Cold miss: after reset, cpu_req=1, addr 0x0000_1014. Bridge model returns words 0x1000_0000+i after 10 cycles. Required: mem_rd_req=1 with mem_addr=0x0000_1000 until gnt; RESP cycle cpu_rdata=0x1000_0005, cpu_stall=0.
- Hit: then addr 0x0000_1000 and 0x0000_101C -> cpu_rdata 0x1000_0000 / 0x1000_0007 same cycle, cpu_stall=0, no mem_rd_req.
- Conflict: addr 0x0000_1814 (same index, different tag) -> miss, refill from 0x0000_1800. Then 0x0000_1014 misses again.
- Flush: flush pulse, then 0x0000_1814 -> miss. flush during REFILL -> word delivered in RESP, next access to the same line misses.
- No re-request: assert mem_rd_req low in the cycle after mem_gnt; exactly one bridge transaction per miss with cpu_req held high.
- Reset mid-REFILL: drop aresetn while mem_rd_req=1 -> mem_rd_req=0 immediately; after release, the previously missed address misses again.
